// File: rtl/iter_div_pkg.sv
// Shared definitions for the iterative restoring divider.
//   - FSM state encodings (IDLE, CALC, DONE)
//   - default operand widths (DW_DEF = dividend/quotient, VW_DEF = divisor/remainder)
//   - clog2 helper used to size the step counter
package iter_div_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t CALC = 2'd1;
    localparam state_t DONE = 2'd2;

    // Defaults match the 2x3 array multiplier this divider inverts:
    // its 5-bit product is the dividend, its 3-bit multiplicand the divisor.
    localparam int DW_DEF = 5;
    localparam int VW_DEF = 3;

    function automatic int clog2(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/iter_div_if.sv
// Operand/result handshake bundle for iter_div.
//   Input side : in_valid, in_ready, IN1 (dividend, DW), IN2 (divisor, VW)
//   Output side: out_valid, out_ready, Quot (DW), Rem (VW), div_zero
// master = producer of operands / consumer of results, slave = divider.
interface iter_div_if
    import iter_div_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int VW = VW_DEF
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] IN1;
    logic [VW-1:0] IN2;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] Quot;
    logic [VW-1:0] Rem;
    logic          div_zero;

    modport master (
        output in_valid, IN1, IN2, out_ready,
        input  in_ready, out_valid, Quot, Rem, div_zero
    );

    modport slave (
        input  in_valid, IN1, IN2, out_ready,
        output in_ready, out_valid, Quot, Rem, div_zero
    );
endinterface

// File: rtl/iter_div_step.sv
// One combinational restoring-division step.
//   r      : current partial remainder (VW bits)
//   d_bit  : next dividend bit shifted in
//   v      : divisor
//   r_next : partial remainder after the step
//   q_bit  : quotient bit produced by the step
// The trial value is VW+1 bits wide. Since r < v on entry, the trial is
// below 2*v, so the difference after a successful subtract fits in VW bits
// and is computed directly at that width.
module div_step #(
    parameter int VW = 3
) (
    input  logic [VW-1:0] r,
    input  logic          d_bit,
    input  logic [VW-1:0] v,
    output logic [VW-1:0] r_next,
    output logic          q_bit
);
    logic [VW:0] trial;

    always_comb begin
        trial  = {r, d_bit};
        q_bit  = (trial >= {1'b0, v});
        r_next = q_bit ? (trial[VW-1:0] - v) : trial[VW-1:0];
    end
endmodule

// File: rtl/iter_div.sv
// Iterative restoring unsigned divider, one quotient bit per clock.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset (discards any in-flight divide)
//   bus : iter_div_if slave port
//         in_valid/in_ready + IN1/IN2 operands,
//         out_valid/out_ready + Quot/Rem/div_zero result.
// A nonzero divide presents its result DW cycles after the accept edge;
// a zero divisor goes straight to DONE with Quot all ones, Rem 0, div_zero 1.
module iter_div
    import iter_div_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int VW = VW_DEF
) (
    input  logic        clk,
    input  logic        rst,
    iter_div_if.slave   bus
);
    localparam int CW_RAW = clog2(DW);
    localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
    localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);

    state_t        state_reg;
    logic [CW-1:0] cnt_reg;
    logic [DW-1:0] d_reg;
    logic [VW-1:0] v_reg;
    // Partial remainder. Its (VW+1)-th bit is always zero between steps
    // (remainder < divisor), so only VW bits are stored.
    logic [VW-1:0] r_reg;
    logic [DW-1:0] q_reg;
    // Result registers are separate from the working registers so the last
    // result stays put while a new divide is in progress.
    logic [DW-1:0] quot_reg;
    logic [VW-1:0] rem_reg;
    logic          dz_reg;

    logic [VW-1:0] step_r;
    logic          step_q;
    logic [DW-1:0] q_shift;

    div_step #(.VW(VW)) u_step (
        .r      (r_reg),
        .d_bit  (d_reg[DW-1]),
        .v      (v_reg),
        .r_next (step_r),
        .q_bit  (step_q)
    );

    assign q_shift = (q_reg << 1) | DW'(step_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            d_reg     <= '0;
            v_reg     <= '0;
            r_reg     <= '0;
            q_reg     <= '0;
            quot_reg  <= '0;
            rem_reg   <= '0;
            dz_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        d_reg   <= bus.IN1;
                        v_reg   <= bus.IN2;
                        r_reg   <= '0;
                        q_reg   <= '0;
                        cnt_reg <= CNT_LAST;
                        if (bus.IN2 == '0) begin
                            state_reg <= DONE;
                            quot_reg  <= '1;
                            rem_reg   <= '0;
                            dz_reg    <= 1'b1;
                        end else begin
                            state_reg <= CALC;
                            dz_reg    <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    r_reg <= step_r;
                    q_reg <= q_shift;
                    d_reg <= d_reg << 1;
                    if (cnt_reg == '0) begin
                        // Final step: publish the result in the same edge.
                        state_reg <= DONE;
                        quot_reg  <= q_shift;
                        rem_reg   <= step_r;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.out_valid = (state_reg == DONE);
    assign bus.Quot      = quot_reg;
    assign bus.Rem       = rem_reg;
    assign bus.div_zero  = dz_reg;

endmodule
